// File: rtl/constraint_verdict_collector_if.sv
// Bundle of configuration, candidate stream, tag stream and status signals of the verdict collector.
// The collector uses the slave modport; whatever drives candidates uses the master modport.
interface constraint_verdict_collector_if #(
  parameter int NUM_CONS = 8,
  parameter int CNT_W    = 16,
  parameter int TAG_W    = 16
);
  localparam int IDX_W = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1;

  logic                start;
  logic                abort;
  logic [NUM_CONS-1:0] cfg_mask;
  logic [CNT_W-1:0]    cfg_target;
  logic [CNT_W-1:0]    cfg_max_cand;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_CONS-1:0] in_cons;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [TAG_W-1:0]    out_tag;
  logic                busy;
  logic                done;
  logic [1:0]          done_reason;
  logic [CNT_W-1:0]    sat_count;
  logic [CNT_W-1:0]    cand_count;
  logic [IDX_W-1:0]    last_fail_idx;

  modport slave (
    input  start, abort, cfg_mask, cfg_target, cfg_max_cand,
    input  in_valid, in_cons, in_tag, out_ready,
    output in_ready, out_valid, out_tag,
    output busy, done, done_reason, sat_count, cand_count, last_fail_idx
  );

  modport master (
    output start, abort, cfg_mask, cfg_target, cfg_max_cand,
    output in_valid, in_cons, in_tag, out_ready,
    input  in_ready, out_valid, out_tag,
    input  busy, done, done_reason, sat_count, cand_count, last_fail_idx
  );
endinterface

// File: rtl/constraint_verdict_collector.sv
// ANDs the enabled constraint bits of each candidate into a verdict, counts candidates and
// satisfying ones, forwards satisfying tags, and stops on target, budget or abort.
module constraint_verdict_collector #(
  parameter int NUM_CONS = 8,
  parameter int CNT_W    = 16,
  parameter int TAG_W    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  constraint_verdict_collector_if.slave bus
);
  localparam int IDX_W = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_CONS-1:0] r_mask;
  logic [CNT_W-1:0]    r_target;
  logic [CNT_W-1:0]    r_budget;
  logic [CNT_W-1:0]    r_sat;
  logic [CNT_W-1:0]    r_cand;
  logic [1:0]          r_reason;
  logic [IDX_W-1:0]    r_fail_idx;
  logic                r_out_valid;
  logic [TAG_W-1:0]    r_out_tag;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_verdict;
  logic                w_sat_accept;
  logic [IDX_W-1:0]    w_fail_idx;
  logic [CNT_W-1:0]    w_cand_next;
  logic [CNT_W-1:0]    w_sat_next;
  logic                w_target_hit;
  logic                w_budget_hit;

  // A draining output slot frees room in the same cycle, so there is no bubble.
  assign w_in_ready   = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_verdict    = &(bus.in_cons | ~r_mask);
  assign w_sat_accept = w_accept && w_verdict;

  always_comb begin
    w_fail_idx = '0;
    for (int i = NUM_CONS - 1; i >= 0; i--) begin
      if (r_mask[i] && !bus.in_cons[i]) begin
        w_fail_idx = IDX_W'(i);
      end
    end
  end

  assign w_cand_next = (w_accept && r_cand != CNT_MAX) ? r_cand + CNT_W'(1) : r_cand;
  assign w_sat_next  = (w_sat_accept && r_sat != CNT_MAX) ? r_sat + CNT_W'(1) : r_sat;

  // Termination looks at the counts as they will be after this cycle's accept.
  assign w_target_hit = (r_target != '0) && (w_sat_next == r_target);
  assign w_budget_hit = ((r_budget != '0) && (w_cand_next == r_budget)) ||
                        ((r_target == '0) && (r_budget == '0) && (w_cand_next == CNT_MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_target    <= '0;
      r_budget    <= '0;
      r_sat       <= '0;
      r_cand      <= '0;
      r_reason    <= '0;
      r_fail_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
    end else begin
      if (w_sat_accept) begin
        r_out_valid <= 1'b1;
        r_out_tag   <= bus.in_tag;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_mask     <= bus.cfg_mask;
            r_target   <= bus.cfg_target;
            r_budget   <= bus.cfg_max_cand;
            r_sat      <= '0;
            r_cand     <= '0;
            r_reason   <= 2'b00;
            r_fail_idx <= '0;
          end
        end
        S_RUN: begin
          r_cand <= w_cand_next;
          r_sat  <= w_sat_next;
          if (w_accept && !w_verdict) begin
            r_fail_idx <= w_fail_idx;
          end
          if (bus.abort) begin
            r_state  <= S_DONE;
            r_reason <= 2'b11;
          end else if (w_target_hit) begin
            r_state  <= S_DONE;
            r_reason <= 2'b01;
          end else if (w_budget_hit) begin
            r_state  <= S_DONE;
            r_reason <= 2'b10;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_tag       = r_out_tag;
  assign bus.busy          = (r_state == S_RUN);
  assign bus.done          = (r_state == S_DONE);
  assign bus.done_reason   = r_reason;
  assign bus.sat_count     = r_sat;
  assign bus.cand_count    = r_cand;
  assign bus.last_fail_idx = r_fail_idx;
endmodule

// File: tb/tb_constraint_verdict_collector.sv
// Directed and randomized bench for the verdict collector against a cycle-level reference
// model built from the collector's rules (counts, pending tag slot, run mode).
module tb_constraint_verdict_collector;
  localparam int NC   = 8;
  localparam int CW   = 16;
  localparam int TW   = 16;
  localparam int CMAX = 65535;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  constraint_verdict_collector_if #(.NUM_CONS(NC), .CNT_W(CW), .TAG_W(TW)) bus ();

  constraint_verdict_collector #(.NUM_CONS(NC), .CNT_W(CW), .TAG_W(TW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 running, 2 done
  int          m_mode;
  logic [7:0]  m_mask;
  int          m_target, m_budget, m_sat, m_cand, m_fail;
  logic [1:0]  m_reason;
  bit          m_ov;
  logic [15:0] m_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_mask = '0; m_target = 0; m_budget = 0; m_sat = 0; m_cand = 0;
    m_fail = 0; m_reason = 2'b00; m_ov = 0; m_tag = '0;
  endtask

  task automatic compare_all();
    chk("busy",      bus.busy,          (m_mode == 1));
    chk("done",      bus.done,          (m_mode == 2));
    chk("reason",    bus.done_reason,   m_reason);
    chk("sat",       bus.sat_count,     m_sat);
    chk("cand",      bus.cand_count,    m_cand);
    chk("fail_idx",  bus.last_fail_idx, m_fail);
    chk("out_valid", bus.out_valid,     m_ov);
    chk("out_tag",   bus.out_tag,       m_tag);
  endtask

  task automatic defaults();
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.out_ready = 1;
    bus.in_cons = '0; bus.in_tag = '0;
  endtask

  // One clock cycle: predict with the model from the present inputs, then compare.
  task automatic step();
    int first;
    bit ok, ready, acc;
    #1;
    ready = (m_mode == 1) && (!m_ov || bus.out_ready);
    chk("in_ready", bus.in_ready, ready);
    acc = bus.in_valid && ready;
    first = -1;
    for (int i = 0; i < NC; i++)
      if (first < 0 && m_mask[i] && !bus.in_cons[i]) first = i;
    ok = (first < 0);
    if (acc && ok) begin
      m_ov = 1; m_tag = bus.in_tag;
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    if (m_mode != 1) begin
      if (bus.start) begin
        m_mode = 1; m_mask = bus.cfg_mask;
        m_target = int'(bus.cfg_target); m_budget = int'(bus.cfg_max_cand);
        m_sat = 0; m_cand = 0; m_reason = 2'b00; m_fail = 0;
      end
    end else begin
      if (acc) begin
        if (m_cand < CMAX) m_cand++;
        if (ok) begin
          if (m_sat < CMAX) m_sat++;
        end else begin
          m_fail = first;
        end
      end
      if (bus.abort) begin
        m_mode = 2; m_reason = 2'b11;
      end else if (m_target != 0 && m_sat == m_target) begin
        m_mode = 2; m_reason = 2'b01;
      end else if ((m_budget != 0 && m_cand == m_budget) ||
                   (m_target == 0 && m_budget == 0 && m_cand == CMAX)) begin
        m_mode = 2; m_reason = 2'b10;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic start_run(input logic [7:0] mask, input int target, input int budget);
    bus.cfg_mask = mask; bus.cfg_target = CW'(target); bus.cfg_max_cand = CW'(budget);
    bus.start = 1; step(); bus.start = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    defaults();
    bus.cfg_mask = '0; bus.cfg_target = '0; bus.cfg_max_cand = '0;
    #1 rst_n = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // 1: target of two satisfying candidates
    start_run(8'h01, 2, 0);
    bus.in_valid = 1; bus.in_cons = 8'h01; bus.in_tag = 16'd5; step();
    chk("t1_tag5", bus.out_tag, 16'd5);
    bus.in_cons = 8'h00; bus.in_tag = 16'd6; step();
    bus.in_cons = 8'h01; bus.in_tag = 16'd7; step();
    chk("t1_tag7", bus.out_tag, 16'd7);
    chk("t1_sat", bus.sat_count, 16'd2);
    chk("t1_cand", bus.cand_count, 16'd3);
    chk("t1_fail", bus.last_fail_idx, 3'd0);
    chk("t1_reason", bus.done_reason, 2'b01);
    chk("t1_ready", bus.in_ready, 1'b0);
    bus.in_valid = 0; step();

    // 2: budget exhausted with bit 3 always failing
    start_run(8'hFF, 0, 4);
    bus.in_valid = 1; bus.in_cons = 8'hF7;
    for (int i = 0; i < 4; i++) begin
      bus.in_tag = 16'(i); step();
    end
    bus.in_valid = 0;
    chk("t2_sat", bus.sat_count, 16'd0);
    chk("t2_cand", bus.cand_count, 16'd4);
    chk("t2_fail", bus.last_fail_idx, 3'd3);
    chk("t2_reason", bus.done_reason, 2'b10);

    // 3: backpressure then drain-and-accept in one cycle
    start_run(8'h01, 0, 0);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_cons = 8'h01; bus.in_tag = 16'h11; step();
    bus.in_tag = 16'h22; step();
    chk("t3_hold_tag", bus.out_tag, 16'h11);
    chk("t3_ready_low", bus.in_ready, 1'b0);
    chk("t3_cand1", bus.cand_count, 16'd1);
    bus.out_ready = 1; bus.in_tag = 16'h33;
    #1 chk("t3_ready_high", bus.in_ready, 1'b1);
    step();
    chk("t3_new_tag", bus.out_tag, 16'h33);
    chk("t3_valid", bus.out_valid, 1'b1);
    chk("t3_cand2", bus.cand_count, 16'd2);
    bus.in_valid = 0; bus.abort = 1; step(); bus.abort = 0;
    chk("t3_reason", bus.done_reason, 2'b11);

    // 4: target and budget together, target wins
    start_run(8'h01, 1, 1);
    bus.in_valid = 1; bus.in_cons = 8'h01; bus.in_tag = 16'h44; step();
    bus.in_valid = 0;
    chk("t4_reason", bus.done_reason, 2'b01);

    // 5: abort with an in-flight accept; start ignored in RUN; restart clears
    start_run(8'h00, 0, 0);
    bus.in_valid = 1; bus.in_cons = 8'h00;
    for (int i = 0; i < 2; i++) begin
      bus.in_tag = 16'($urandom); step();
    end
    bus.cfg_mask = 8'hFF; bus.start = 1; step(); bus.start = 0;
    chk("t5_no_restart", bus.cand_count, 16'd3);
    chk("t5_busy", bus.busy, 1'b1);
    bus.abort = 1; step(); bus.abort = 0; bus.in_valid = 0;
    chk("t5_cand", bus.cand_count, 16'd4);
    chk("t5_reason", bus.done_reason, 2'b11);
    start_run(8'h00, 0, 0);
    chk("t5_clr_cand", bus.cand_count, 16'd0);
    chk("t5_clr_sat", bus.sat_count, 16'd0);
    chk("t5_clr_reason", bus.done_reason, 2'b00);
    bus.abort = 1; step(); bus.abort = 0;

    // 6: asynchronous reset mid-run with a pending tag
    start_run(8'h01, 0, 0);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_cons = 8'h01; bus.in_tag = 16'h55; step();
    bus.in_valid = 0;
    chk("t6_pending", bus.out_valid, 1'b1);
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("t6_valid_drop", bus.out_valid, 1'b0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    defaults();

    // Randomized runs against the model
    for (int run = 0; run < 8; run++) begin
      logic [7:0] mask;
      mask = 8'($urandom);
      if ($urandom_range(0, 4) == 0) mask = 8'h00;
      start_run(mask, $urandom_range(0, 6), $urandom_range(0, 10));
      for (int cyc = 0; cyc < 150 && m_mode == 1; cyc++) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        bus.in_cons   = 8'($urandom | $urandom | $urandom);
        bus.in_tag    = 16'($urandom);
        bus.abort     = ($urandom_range(0, 59) == 0);
        bus.start     = ($urandom_range(0, 29) == 0);
        step();
      end
      defaults();
      if (m_mode == 1) begin
        bus.abort = 1; step(); bus.abort = 0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
